// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified I/D memory port arbiter.
//   arb_state_t : FSM state encoding (IDLE, BUSY_I, BUSY_D)
//   REQ_I/REQ_D : requester identifiers used for grant selection
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Busy-cycle watchdog for the memory port arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count (asserted on the grant that enters BUSY)
//   enable   : count this cycle (BUSY and no mem_ack)
//   expire   : this cycle is the last allowed ack-less BUSY cycle
// TIMEOUT_CYCLES = 0 removes the counter entirely and expire stays low.
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_cnt
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Gated by enable so an ack in the expiry cycle wins over the abort.
            assign expire = enable && (cnt == LAST);
        end else begin : g_none
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between fetch (I) and
// memory stage (D). One request is latched per transaction and presented to
// the memory until mem_ack (or a timeout abort); the result returns with a
// one-cycle done pulse.
//
// Handshake: a requester raises x_req with stable address/data and holds it
// until it sees x_done=1; x_done is a single-cycle pulse and x_rdata is valid
// only while x_done=1. On the memory side mem_req stays high with stable
// mem_we/mem_addr/mem_wdata until the one-cycle mem_ack pulse, in which
// mem_rdata is sampled.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_req, i_addr             fetch read request
//   i_rdata, i_done           fetch result and completion pulse
//   d_req, d_we, d_addr,
//   d_wdata                   data-stage request
//   d_rdata, d_done           data-stage result and completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata                 memory command (held through BUSY)
//   mem_rdata, mem_ack        memory response
//   stall_fetch, stall_mem    per-stage stall requests (x_req & ~x_done)
//   busy                      FSM not in IDLE (state visibility)
//   err_timeout               sticky timeout-abort flag
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// D has fixed priority over I.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_fetch,
    output logic          stall_mem,
    output logic          busy,
    output logic          err_timeout
);

    import mem_arb_pkg::*;

    arb_state_t state, state_next;
    logic       grant;
    logic       gnt_id;
    logic       finish;
    logic       timeout;
    logic       done_any;

    assign busy        = (state != IDLE);
    assign mem_req     = busy;
    assign stall_fetch = i_req & ~i_done;
    assign stall_mem   = d_req & ~d_done;

    // The cycle carrying a done pulse is the forced IDLE gap: the finishing
    // requester still holds its req there, so no new grant is made.
    assign done_any = i_done | d_done;

`ifdef MEM_ARB_RR_EN
    logic last_gnt;

    always_comb begin
        if (i_req && d_req) begin
            gnt_id = (last_gnt == REQ_I) ? REQ_D : REQ_I;
        end else begin
            gnt_id = d_req ? REQ_D : REQ_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= REQ_I;
        end else if (grant) begin
            last_gnt <= gnt_id;
        end
    end
`else
    assign gnt_id = d_req ? REQ_D : REQ_I;
`endif

    arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .enable (busy & ~mem_ack),
        .expire (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if ((i_req || d_req) && !done_any) begin
                    grant      = 1'b1;
                    state_next = (gnt_id == REQ_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || timeout) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            i_done <= finish && (state == BUSY_I);
            d_done <= finish && (state == BUSY_D);

            if (grant) begin
                if (gnt_id == REQ_D) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                end
            end

            if (finish) begin
                // Aborted transactions and writes return zero data.
                if (state == BUSY_I) begin
                    i_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                end
                if (!mem_ack) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule
